// File: rtl/addroundkey_stage.sv
// AES AddRoundKey pipeline stage. It tracks the round index of each block and XORs the
// round key onto either the ShiftRows or the MixColumns result, buffering beats in a 2-entry skid buffer.
module addroundkey_stage #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_first,
  input  logic [127:0] shifted,
  input  logic [127:0] mixed,
  input  logic [127:0] round_key,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_state,
  output logic [3:0]   m_round,
  output logic         m_last,
  output logic         round_err
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RUN     = 1'b1;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  logic [0:0]   state_q, state_d;
  logic [3:0]   next_round_q, next_round_d;
  logic         err_q, err_d;

  logic         main_valid_q, main_valid_d;
  logic [127:0] main_state_q, main_state_d;
  logic [3:0]   main_round_q, main_round_d;
  logic         skid_valid_q, skid_valid_d;
  logic [127:0] skid_state_q, skid_state_d;
  logic [3:0]   skid_round_q, skid_round_d;

  logic         accept;
  logic         drain;
  logic         beat_ok;
  logic [127:0] beat_data;
  logic [3:0]   beat_round;

  assign s_ready = ~skid_valid_q;
  assign accept  = s_valid & s_ready;
  assign drain   = main_valid_q & m_ready;

  // Round sequencing: a first beat always restarts the block, the final round bypasses
  // MixColumns, and a non-first beat with no block in progress is dropped and flagged.
  always_comb begin
    state_d      = state_q;
    next_round_d = next_round_q;
    err_d        = 1'b0;
    beat_ok      = 1'b0;
    beat_data    = '0;
    beat_round   = '0;
    if (accept) begin
      if (s_first) begin
        beat_ok      = 1'b1;
        beat_data    = shifted ^ round_key;
        beat_round   = 4'd0;
        state_d      = ST_RUN;
        next_round_d = 4'd1;
      end else if (state_q == ST_RUN) begin
        beat_ok    = 1'b1;
        beat_round = next_round_q;
        if (next_round_q == LAST_ROUND) begin
          beat_data    = shifted ^ round_key;
          state_d      = ST_IDLE;
          next_round_d = 4'd0;
        end else begin
          beat_data    = mixed ^ round_key;
          next_round_d = next_round_q + 4'd1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Skid buffer: while skid holds a beat nothing is accepted, so the only move is skid to
  // main on a drain; otherwise a new beat lands in main if it is free or leaving, else in skid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_state_d = main_state_q;
    main_round_d = main_round_q;
    skid_valid_d = skid_valid_q;
    skid_state_d = skid_state_q;
    skid_round_d = skid_round_q;
    if (skid_valid_q) begin
      if (drain) begin
        main_state_d = skid_state_q;
        main_round_d = skid_round_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q && !drain) begin
      if (beat_ok) begin
        skid_valid_d = 1'b1;
        skid_state_d = beat_data;
        skid_round_d = beat_round;
      end
    end else begin
      main_valid_d = beat_ok;
      if (beat_ok) begin
        main_state_d = beat_data;
        main_round_d = beat_round;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      next_round_q <= 4'd0;
      err_q        <= 1'b0;
      main_valid_q <= 1'b0;
      main_state_q <= '0;
      main_round_q <= 4'd0;
      skid_valid_q <= 1'b0;
      skid_state_q <= '0;
      skid_round_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      next_round_q <= next_round_d;
      err_q        <= err_d;
      main_valid_q <= main_valid_d;
      main_state_q <= main_state_d;
      main_round_q <= main_round_d;
      skid_valid_q <= skid_valid_d;
      skid_state_q <= skid_state_d;
      skid_round_q <= skid_round_d;
    end
  end

  assign m_valid   = main_valid_q;
  assign m_state   = main_state_q;
  assign m_round   = main_round_q;
  assign m_last    = main_valid_q && (main_round_q == LAST_ROUND);
  assign round_err = err_q;

endmodule

// File: tb/tb_addroundkey_stage.sv
// Bench for addroundkey_stage: an AES-128 reference model supplies the FIPS-197 C.1 round
// inputs, directed scenarios cover handshake corners, and a random pass uses a scoreboard.
module tb_addroundkey_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic         s_first;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] round_key;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_state;
  logic [3:0]   m_round;
  logic         m_last;
  logic         round_err;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox [256];
  logic [127:0] vSh  [11];
  logic [127:0] vMx  [11];
  logic [127:0] vKey [11];
  logic [127:0] vExp [11];

  addroundkey_stage #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_first(s_first),
    .shifted(shifted), .mixed(mixed), .round_key(round_key), .m_valid(m_valid),
    .m_ready(m_ready), .m_state(m_state), .m_round(m_round), .m_last(m_last),
    .round_err(round_err)
  );

  always #5 clk = ~clk;

  // GF(2^8) arithmetic used to build the S-box and MixColumns
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r1, r2, r3, r4;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r1 = rotl1(inv);
      r2 = rotl1(r1);
      r3 = rotl1(r2);
      r4 = rotl1(r3);
      sbox[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
      o[127-8*(4*c+3) -: 8] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
    end
    return o;
  endfunction

  // FIPS-197 C.1: per-round stage inputs and the state each round should produce
  task automatic build_vectors();
    logic [127:0] pt  = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] key = 128'h000102030405060708090a0b0c0d0e0f;
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcon [10];
    rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    build_sbox();
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon[i/4-1];
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) vKey[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    vSh[0]  = pt;
    vMx[0]  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    vExp[0] = pt ^ vKey[0];
    for (int r = 1; r < 11; r++) begin
      vSh[r]  = shift_rows(sub_bytes(vExp[r-1]));
      vMx[r]  = mix_columns(vSh[r]);
      vExp[r] = ((r == 10) ? vSh[r] : vMx[r]) ^ vKey[r];
    end
  endtask

  task automatic drive_beat(input logic first, input int r);
    s_valid   = 1'b1;
    s_first   = first;
    shifted   = vSh[r];
    mixed     = vMx[r];
    round_key = vKey[r];
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_m_valid: got %b expected 0", m_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
    checks++;
    if (m_state !== 128'h0) begin errors++; $display("FAIL reset_m_state: got %h expected 0", m_state); end
    checks++;
    if (m_round !== 4'd0) begin errors++; $display("FAIL reset_m_round: got %0d expected 0", m_round); end
    checks++;
    if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
    checks++;
    if (round_err !== 1'b0) begin errors++; $display("FAIL reset_round_err: got %b expected 0", round_err); end
  endtask

  task automatic test_round0();
    @(negedge clk);
    m_ready = 1'b0;
    drive_beat(1'b1, 0);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL round0_latency: got m_valid=%b expected 1", m_valid); end
    checks++;
    if (m_state !== 128'h00102030405060708090a0b0c0d0e0f0)
      begin errors++; $display("FAIL round0_state: got %h expected 00102030405060708090a0b0c0d0e0f0", m_state); end
    checks++;
    if ({m_round, m_last} !== {4'd0, 1'b0})
      begin errors++; $display("FAIL round0_tag: got round=%0d last=%b expected round=0 last=0", m_round, m_last); end
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL round0_drain: got m_valid=%b expected 0", m_valid); end
  endtask

  // Eleven rounds back to back with the sink always ready; one output per cycle
  task automatic test_full_block(input string tag);
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        checks++;
        if ({m_valid, m_round, m_last, m_state} !== {1'b1, 4'(i-1), (i == 11), vExp[i-1]})
          $display("FAIL %s_beat%0d: got v=%b r=%0d l=%b %h expected v=1 r=%0d l=%b %h",
                   tag, i-1, m_valid, m_round, m_last, m_state, i-1, (i == 11), vExp[i-1]);
        if ({m_valid, m_round, m_last, m_state} !== {1'b1, 4'(i-1), (i == 11), vExp[i-1]}) errors++;
      end
      if (i == 11) begin
        checks++;
        if (m_state !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a)
          begin errors++; $display("FAIL %s_ciphertext: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", tag, m_state); end
      end
      if (i <= 10) drive_beat(i == 0, i);
      else s_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL %s_idle_after: got m_valid=%b expected 0", tag, m_valid); end
  endtask

  // First pass follows a completed round 10, second pass follows a reset
  task automatic test_protocol_err();
    for (int k = 0; k < 2; k++) begin
      if (k == 1) pulse_reset();
      @(negedge clk);
      m_ready = 1'b1;
      drive_beat(1'b0, 1);
      @(negedge clk);
      s_valid = 1'b0;
      checks++;
      if ({round_err, m_valid} !== 2'b10)
        begin errors++; $display("FAIL stray%0d_pulse: got err=%b m_valid=%b expected err=1 m_valid=0", k, round_err, m_valid); end
      @(negedge clk);
      checks++;
      if ({round_err, m_valid} !== 2'b00)
        begin errors++; $display("FAIL stray%0d_after: got err=%b m_valid=%b expected err=0 m_valid=0", k, round_err, m_valid); end
    end
    drive_beat(1'b1, 0);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if ({m_valid, m_round, m_state} !== {1'b1, 4'd0, vExp[0]})
      begin errors++; $display("FAIL recover_first: got v=%b r=%0d %h expected v=1 r=0 %h", m_valid, m_round, m_state, vExp[0]); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b0;
    @(negedge clk);
    drive_beat(1'b1, 0);
    @(negedge clk);
    checks++;
    if ({s_ready, m_state} !== {1'b1, vExp[0]})
      begin errors++; $display("FAIL bp_first: got rdy=%b %h expected rdy=1 %h", s_ready, m_state, vExp[0]); end
    drive_beat(1'b0, 1);
    @(negedge clk);
    checks++;
    if ({s_ready, m_valid, m_state} !== {1'b0, 1'b1, vExp[0]})
      begin errors++; $display("FAIL bp_skid_full: got rdy=%b v=%b %h expected rdy=0 v=1 %h", s_ready, m_valid, m_state, vExp[0]); end
    drive_beat(1'b0, 2);
    @(negedge clk);
    checks++;
    if ({s_ready, m_valid, m_round, m_state} !== {1'b0, 1'b1, 4'd0, vExp[0]})
      begin errors++; $display("FAIL bp_hold: got rdy=%b v=%b r=%0d %h expected rdy=0 v=1 r=0 %h", s_ready, m_valid, m_round, m_state, vExp[0]); end
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready, m_valid, m_round, m_state} !== {1'b1, 1'b1, 4'd1, vExp[1]})
      begin errors++; $display("FAIL bp_out2: got rdy=%b v=%b r=%0d %h expected rdy=1 v=1 r=1 %h", s_ready, m_valid, m_round, m_state, vExp[1]); end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if ({m_valid, m_round, m_state} !== {1'b1, 4'd2, vExp[2]})
      begin errors++; $display("FAIL bp_out3: got v=%b r=%0d %h expected v=1 r=2 %h", m_valid, m_round, m_state, vExp[2]); end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got m_valid=%b expected 0", m_valid); end
  endtask

  task automatic test_reset_midblock();
    m_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      drive_beat(r == 0, r);
    end
    @(negedge clk);
    m_ready = 1'b0;
    drive_beat(1'b0, 5);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if ({s_ready, m_valid, m_round} !== {1'b0, 1'b1, 4'd4})
      begin errors++; $display("FAIL mid_full: got rdy=%b v=%b r=%0d expected rdy=0 v=1 r=4", s_ready, m_valid, m_round); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_valid, s_ready, m_round, m_state} !== {1'b0, 1'b1, 4'd0, 128'h0})
      begin errors++; $display("FAIL mid_async_reset: got v=%b rdy=%b r=%0d %h expected v=0 rdy=1 r=0 0", m_valid, s_ready, m_round, m_state); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_full_block("after_reset");
  endtask

  // Random valid/ready against a scoreboard of random round inputs, 1000 blocks
  task automatic test_random();
    logic [132:0] q[$];
    logic [132:0] exp;
    logic [127:0] sh, mx, key;
    int blk = 0, r = 0, cycles = 0, outs = 0, errPulses = 0;
    bit pend = 1'b0;
    s_valid = 1'b0;
    while ((blk < 1000 || q.size() != 0) && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      if (round_err) errPulses++;
      if (!pend && blk < 1000) begin
        sh   = {$urandom, $urandom, $urandom, $urandom};
        mx   = {$urandom, $urandom, $urandom, $urandom};
        key  = {$urandom, $urandom, $urandom, $urandom};
        pend = 1'b1;
      end
      s_valid   = pend && ($urandom_range(3) != 0);
      s_first   = (r == 0);
      shifted   = sh;
      mixed     = mx;
      round_key = key;
      m_ready   = ($urandom_range(3) != 0);
      if (m_valid && m_ready) begin
        checks++;
        outs++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected: got r=%0d %h expected no output", m_round, m_state);
        end else begin
          exp = q.pop_front();
          if ({m_round, m_last, m_state} !== exp) begin
            errors++;
            $display("FAIL rand_beat%0d: got r=%0d l=%b %h expected r=%0d l=%b %h",
                     outs, m_round, m_last, m_state, exp[132:129], exp[128], exp[127:0]);
          end
        end
      end
      if (s_valid && s_ready) begin
        q.push_back({4'(r), (r == 10), ((r == 0 || r == 10) ? sh : mx) ^ key});
        pend = 1'b0;
        r++;
        if (r == 11) begin
          r = 0;
          blk++;
        end
      end
    end
    s_valid = 1'b0;
    checks++;
    if (cycles >= 60000) begin errors++; $display("FAIL rand_timeout: got %0d cycles expected under 60000", cycles); end
    checks++;
    if (outs != 11000) begin errors++; $display("FAIL rand_count: got %0d outputs expected 11000", outs); end
    checks++;
    if (errPulses != 0) begin errors++; $display("FAIL rand_round_err: got %0d pulses expected 0", errPulses); end
  endtask

  initial begin
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_first   = 1'b0;
    shifted   = '0;
    mixed     = '0;
    round_key = '0;
    m_ready   = 1'b0;
    build_vectors();
    test_reset();
    test_round0();
    test_full_block("fips_block");
    test_protocol_err();
    test_back_to_back();
    test_reset_midblock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addroundkey_stage.md
ADDROUNDKEY_STAGE -- requirements
Module: addroundkey_stage

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, the final round index (AES-128).
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port s_valid, input, 1: upstream beat valid.
REQ-005 SHALL have port s_ready, output, 1: stage can accept a beat.
REQ-006 SHALL have port s_first, input, 1: beat is round 0 (initial key add; shifted carries plaintext).
REQ-007 SHALL have port shifted, input, 128: ShiftRows output (or plaintext when s_first).
REQ-008 SHALL have port mixed, input, 128: MixColumns output for the same beat.
REQ-009 SHALL have port round_key, input, 128: round key for the beat, sampled with it.
REQ-010 SHALL have port m_valid, output, 1: output beat valid.
REQ-011 SHALL have port m_ready, input, 1: downstream accepts.
REQ-012 SHALL have port m_state, output, 128: state after AddRoundKey.
REQ-013 SHALL have port m_round, output, 4: round index of m_state.
REQ-014 SHALL have port m_last, output, 1: m_round equals NUM_ROUNDS (ciphertext).
REQ-015 SHALL have port round_err, output, 1: one-cycle pulse on protocol violation.

Function
REQ-016 Accept = s_valid and s_ready; transfer out = m_valid and m_ready.
REQ-017 Round FSM states: IDLE (expects s_first) and RUN (holds next round 1..NUM_ROUNDS).
REQ-018 Accept with s_first, any state: data = shifted xor round_key, round 0, FSM to RUN with next round 1.
REQ-019 Accept without s_first in RUN, next round r < NUM_ROUNDS: data = mixed xor round_key, round r, next round r+1.
REQ-020 Accept without s_first in RUN, r = NUM_ROUNDS: data = shifted xor round_key (MixColumns bypassed), round r, FSM to IDLE.
REQ-021 Accept without s_first in IDLE: beat dropped (not enqueued), round_err high the next cycle, FSM stays IDLE.
REQ-022 s_first accepted in RUN: previous block abandoned without error; restarts per REQ-018.
REQ-023 Output is registered; latency accept to m_valid is exactly 1 cycle when the buffer is empty.
REQ-024 Two-entry skid buffer (main + skid): s_ready = not skid_valid, registered, no combinational path from m_ready.
REQ-025 Accept while main full and not draining: beat goes to skid; s_ready low next cycle.
REQ-026 Main draining with skid valid: skid moves to main the same edge; skid empties, s_ready high next cycle.
REQ-027 Accept and drain in the same cycle with skid empty: new beat replaces main; m_valid stays high.
REQ-028 Beats leave in accept order; m_state, m_round and m_last stay stable while m_valid high and m_ready low.
REQ-029 m_last is derived from stored round and asserted only with m_valid.
REQ-030 Throughput: one beat per cycle sustained while m_ready is held high.

Reset
REQ-031 rst high, asynchronously: m_valid 0, skid_valid 0, s_ready 1 (once rst low), m_state 0, m_round 0, m_last 0, round_err 0, FSM IDLE.
REQ-032 Reset mid-block discards all buffered beats; first beat after reset must carry s_first, else REQ-021 applies.

Verification
REQ-033 Round 0: s_first, shifted=00112233445566778899aabbccddeeff, round_key=000102030405060708090a0b0c0d0e0f -> next cycle m_state=00102030405060708090a0b0c0d0e0f0, m_round=0, m_last=0.
REQ-034 Full FIPS-197 C.1 block, 11 back-to-back beats, m_ready=1 -> 11 outputs on consecutive cycles, round 10 m_state=69c4e0d86a7b0430d8cdb78070b4c55a, m_last=1 only there.
REQ-035 m_ready=0 for 3 cycles while 3 beats offered -> main+skid fill, s_ready low after 2nd accept, 3rd held; after release all three out in order, none lost or duplicated.
REQ-036 Beat without s_first after reset or after round 10 -> no output, round_err one-cycle pulse; next s_first beat processed normally.
REQ-037 rst asserted with both entries full at round 5 -> m_valid falls immediately (asynchronous); after release a new s_first block completes with correct values.
REQ-038 Randomised s_valid/m_ready back-pressure against a reference model across 1000 blocks -> bit-exact outputs, ordering preserved, no protocol errors.
